// File: rtl/motor_pulse_ctrl.sv
// Prescaled single-pulse H-bridge driver: one fixed-length drive pulse per direction command.
// Define MOTOR_DEADTIME_EN to insert DEAD_W ticks of bridge-off time before a direction reversal.
module motor_pulse_ctrl #(
    parameter int DIV     = 4,
    parameter int PULSE_W = 3,
    parameter int DEAD_W  = 2
) (
    input  logic       orgclk,
    input  logic       rst_n,
    input  logic [1:0] cmd,
    output logic [1:0] out,
    output logic       busy,
    output logic       done
);

    // state   | meaning
    // IDLE    | bridge off, waiting for a direction command
    // PULSE   | driving the bridge in r_dir for PULSE_W ticks
    // HOLD    | pulse finished, bridge off until cmd changes
    // DEAD    | bridge off for DEAD_W ticks before a reversal

    if (DIV < 1 || PULSE_W < 1 || DEAD_W < 1) begin : g_bad_param
        $error("motor_pulse_ctrl: DIV, PULSE_W and DEAD_W must all be >= 1");
    end

    localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PCW = $clog2(PULSE_W + 1);

    localparam logic [1:0] D_NONE = 2'b00;
    localparam logic [1:0] D_FWD  = 2'b01;
    localparam logic [1:0] D_REV  = 2'b10;
    localparam logic [1:0] C_STOP = 2'b00;
    localparam logic [1:0] C_REL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_HOLD  = 2'd2
`ifdef MOTOR_DEADTIME_EN
        , S_DEAD = 2'd3
`endif
    } state_t;

    logic [PSW-1:0] r_presc;
    logic           w_tick;

    assign w_tick = (r_presc == PSW'(DIV - 1));

    always_ff @(posedge orgclk or negedge rst_n) begin
        if (!rst_n)      r_presc <= '0;
        else if (w_tick) r_presc <= '0;
        else             r_presc <= r_presc + 1'b1;
    end

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_dir, w_dir_nxt;
    logic [1:0]     r_last_dir, w_last_dir_nxt;
    logic [PCW-1:0] r_pcnt, w_pcnt_nxt;
    logic [1:0]     r_out, w_out_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;
    logic           w_cmd_is_dir;

    assign w_cmd_is_dir = (cmd == D_FWD) || (cmd == D_REV);

`ifdef MOTOR_DEADTIME_EN
    localparam int DCW = $clog2(DEAD_W + 1);
    logic [DCW-1:0] r_dcnt, w_dcnt_nxt;
    logic           w_need_dead;

    // Only a genuine reversal against a remembered direction costs dead time.
    assign w_need_dead = (r_last_dir != D_NONE) && (cmd != r_last_dir);

    always_ff @(posedge orgclk or negedge rst_n) begin
        if (!rst_n) r_dcnt <= '0;
        else        r_dcnt <= w_dcnt_nxt;
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_dir_nxt      = r_dir;
        w_last_dir_nxt = r_last_dir;
        w_pcnt_nxt     = r_pcnt;
        w_done_nxt     = 1'b0;
`ifdef MOTOR_DEADTIME_EN
        w_dcnt_nxt     = r_dcnt;
`endif
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (cmd == C_REL) begin
                        w_last_dir_nxt = D_NONE;
                    end else if (w_cmd_is_dir) begin
                        w_dir_nxt = cmd;
`ifdef MOTOR_DEADTIME_EN
                        if (w_need_dead) begin
                            w_state_nxt = S_DEAD;
                            w_dcnt_nxt  = DCW'(DEAD_W - 1);
                        end else
`endif
                        begin
                            w_state_nxt = S_PULSE;
                            w_pcnt_nxt  = PCW'(PULSE_W - 1);
                        end
                    end
                end
                S_PULSE: begin
                    if (r_pcnt == '0) begin
                        w_state_nxt    = S_HOLD;
                        w_done_nxt     = 1'b1;
                        w_last_dir_nxt = r_dir;
                    end else begin
                        w_pcnt_nxt = r_pcnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cmd == C_STOP) begin
                        w_state_nxt = S_IDLE;
                    end else if (cmd == C_REL) begin
                        w_state_nxt    = S_IDLE;
                        w_last_dir_nxt = D_NONE;
                    end else if (cmd != r_dir) begin
                        w_dir_nxt = cmd;
`ifdef MOTOR_DEADTIME_EN
                        if (w_need_dead) begin
                            w_state_nxt = S_DEAD;
                            w_dcnt_nxt  = DCW'(DEAD_W - 1);
                        end else
`endif
                        begin
                            w_state_nxt = S_PULSE;
                            w_pcnt_nxt  = PCW'(PULSE_W - 1);
                        end
                    end
                end
`ifdef MOTOR_DEADTIME_EN
                S_DEAD: begin
                    if (r_dcnt == '0) begin
                        if (w_cmd_is_dir) begin
                            w_dir_nxt   = cmd;
                            w_state_nxt = S_PULSE;
                            w_pcnt_nxt  = PCW'(PULSE_W - 1);
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_dcnt_nxt = r_dcnt - 1'b1;
                    end
                end
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they land on the transition edge.
        w_out_nxt  = (w_state_nxt == S_PULSE) ? w_dir_nxt : 2'b00;
        w_busy_nxt = (w_state_nxt == S_PULSE);
`ifdef MOTOR_DEADTIME_EN
        if (w_state_nxt == S_DEAD) w_busy_nxt = 1'b1;
`endif
    end

    always_ff @(posedge orgclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dir      <= D_NONE;
            r_last_dir <= D_NONE;
            r_pcnt     <= '0;
            r_out      <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_last_dir <= w_last_dir_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_out      <= w_out_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_motor_pulse_ctrl.sv
// Bench for motor_pulse_ctrl: directed scenarios plus random commands against a tick-level model.
// Expectations follow MOTOR_DEADTIME_EN when it is defined for the build.
module tb_motor_pulse_ctrl;

    localparam int DIV     = 4;
    localparam int PULSE_W = 3;
    localparam int DEAD_W  = 2;
`ifdef MOTOR_DEADTIME_EN
    localparam bit DEADEN = 1'b1;
`else
    localparam bit DEADEN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_PULSE = 1;
    localparam int M_HOLD  = 2;
    localparam int M_DEAD  = 3;

    logic       orgclk = 1'b0;
    logic       rst_n;
    logic [1:0] cmd;
    logic [1:0] out_w;
    logic       busy_w;
    logic       done_w;

    motor_pulse_ctrl #(.DIV(DIV), .PULSE_W(PULSE_W), .DEAD_W(DEAD_W)) dut (
        .orgclk (orgclk),
        .rst_n  (rst_n),
        .cmd    (cmd),
        .out    (out_w),
        .busy   (busy_w),
        .done   (done_w)
    );

    always #5 orgclk = ~orgclk;

    int n_checks = 0;
    int n_err    = 0;
    int n_fwd, n_rev, n_dead, n_done;

    // Reference model: mode plus ticks remaining in the current timed phase.
    int         m_ps;
    int         m_mode;
    int         m_left;
    logic [1:0] m_dir, m_last;
    logic [1:0] m_out;
    logic       m_busy, m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ps = 0; m_mode = M_IDLE; m_left = 0;
        m_dir = 2'b00; m_last = 2'b00;
        m_out = 2'b00; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic start_move(input logic [1:0] c);
        m_dir = c;
        if (DEADEN && m_last != 2'b00 && m_last != c) begin
            m_mode = M_DEAD; m_left = DEAD_W;
        end else begin
            m_mode = M_PULSE; m_left = PULSE_W;
        end
    endtask

    task automatic model_step(input logic [1:0] c);
        bit tick;
        tick = (m_ps == DIV - 1);
        m_ps = tick ? 0 : m_ps + 1;
        m_done = 1'b0;
        if (tick) begin
            case (m_mode)
                M_IDLE: begin
                    if (c == 2'b11) m_last = 2'b00;
                    else if (c != 2'b00) start_move(c);
                end
                M_PULSE: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_HOLD; m_done = 1'b1; m_last = m_dir;
                    end
                end
                M_HOLD: begin
                    if (c == 2'b00) m_mode = M_IDLE;
                    else if (c == 2'b11) begin m_mode = M_IDLE; m_last = 2'b00; end
                    else if (c != m_dir) start_move(c);
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (c == 2'b01 || c == 2'b10) begin
                            m_dir = c; m_mode = M_PULSE; m_left = PULSE_W;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            endcase
        end
        m_out  = (m_mode == M_PULSE) ? m_dir : 2'b00;
        m_busy = (m_mode == M_PULSE) || (m_mode == M_DEAD);
    endtask

    task automatic clear_counts();
        n_fwd = 0; n_rev = 0; n_dead = 0; n_done = 0;
    endtask

    task automatic cycle();
        if (rst_n) model_step(cmd);
        else       model_reset();
        @(posedge orgclk);
        #1;
        chk("out", out_w, m_out);
        chk("busy", busy_w, m_busy);
        chk("done", done_w, m_done);
        chk("out_never_11", (out_w == 2'b11), 1'b0);
        if (out_w == 2'b01) n_fwd++;
        if (out_w == 2'b10) n_rev++;
        if (busy_w && out_w == 2'b00) n_dead++;
        if (done_w) n_done++;
    endtask

    task automatic wait_out(input string tag, input logic [1:0] v);
        int k;
        k = 0;
        while (out_w !== v && k < 60) begin
            cycle();
            k++;
        end
        chk(tag, out_w, v);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd   = 2'b00;
        clear_counts();
        model_reset();
        repeat (3) cycle();
        chk("reset_out", out_w, 2'b00);
        rst_n = 1'b1;

        // Forward command held: one pulse only.
        clear_counts();
        cmd = 2'b01;
        repeat (40) cycle();
        chk("fwd_len", n_fwd, PULSE_W * DIV);
        chk("fwd_done", n_done, 1);
        chk("fwd_hold_out", out_w, 2'b00);

        // Reversal from HOLD.
        clear_counts();
        cmd = 2'b10;
        repeat (40) cycle();
        chk("rev_dead_len", n_dead, DEADEN ? DEAD_W * DIV : 0);
        chk("rev_len", n_rev, PULSE_W * DIV);
        chk("rev_done", n_done, 1);

        // Command dropped mid-pulse: pulse still runs full length.
        cmd = 2'b00;
        repeat (8) cycle();
        clear_counts();
        cmd = 2'b01;
        wait_out("mid_drop_start", 2'b01);
        repeat (4) cycle();
        cmd = 2'b00;
        repeat (20) cycle();
        chk("mid_drop_len", n_fwd, PULSE_W * DIV);
        chk("mid_drop_idle_busy", busy_w, 1'b0);

        // Release clears last direction: no dead time on the following reversal.
        cmd = 2'b01;
        repeat (24) cycle();
        cmd = 2'b11;
        repeat (DIV) cycle();
        clear_counts();
        cmd = 2'b10;
        repeat (24) cycle();
        chk("rel_no_dead", n_dead, 0);
        chk("rel_rev_len", n_rev, PULSE_W * DIV);

        // Asynchronous reset mid-pulse.
        cmd = 2'b00;
        repeat (8) cycle();
        cmd = 2'b01;
        wait_out("rst_pulse_start", 2'b01);
        repeat (5) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", out_w, 2'b00);
        chk("async_rst_busy", busy_w, 1'b0);
        repeat (3) cycle();
        rst_n = 1'b1;
        clear_counts();
        repeat (30) cycle();
        chk("post_rst_len", n_fwd, PULSE_W * DIV);
        chk("post_rst_done", n_done, 1);

        // Random command sequences with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) cycle();
                rst_n = 1'b1;
            end
            cmd = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 20)) cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
